// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame width and the
// clocks-per-bit helper used by both the receiver and transmitter.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_state_e;

  // Integer division; the result must land in 4..65535 for a 16-bit counter.
  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                    input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
// RESET_VAL sets the value both flops take during reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling; define UART_RX_PARITY_EN for 8E1
// framing with a parity_err pulse. fsm_state exposes the FSM for debug.
// Handshake: rx_valid is a one-cycle pulse with rx_data stable from that
// edge until the next good frame; there is no ready, so no backpressure.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq  = 50000000,
  parameter int unsigned baud_rate = 9600
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_line,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_busy,
  output logic        frame_err,
  output logic        parity_err,
  output uart_state_e fsm_state
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(clk_freq, baud_rate);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST    = 16'(HALF_BIT - 1);
  localparam logic [2:0]  INDEX_LAST   = 3'(DATA_BITS - 1);

  logic        rx_s;
  uart_state_e state, state_next;
  logic [15:0] clk_count, count_next;
  logic [2:0]  bit_index, index_next;
  logic [7:0]  shift, shift_next;
  logic [7:0]  data_next;
  logic        valid_next, ferr_next;
`ifdef UART_RX_PARITY_EN
  logic        parity_bit, parity_next, perr_next;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx_line),
    .q       (rx_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      clk_count <= '0;
      bit_index <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      clk_count <= count_next;
      bit_index <= index_next;
      shift     <= shift_next;
      rx_data   <= data_next;
      rx_valid  <= valid_next;
      frame_err <= ferr_next;
`ifdef UART_RX_PARITY_EN
      parity_bit <= parity_next;
      parity_err <= perr_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    count_next = clk_count;
    index_next = bit_index;
    shift_next = shift;
    data_next  = rx_data;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_next = parity_bit;
    perr_next   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          count_next = '0;
        end
      end
      START: begin
        // A start bit still low at mid-bit is real; anything shorter is a glitch.
        if (clk_count == HALF_LAST) begin
          count_next = '0;
          index_next = '0;
          state_next = rx_s ? IDLE : DATA;
        end else begin
          count_next = clk_count + 16'd1;
        end
      end
      DATA: begin
        if (clk_count == BIT_LAST) begin
          count_next            = '0;
          shift_next[bit_index] = rx_s;
          if (bit_index == INDEX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            index_next = bit_index + 3'd1;
          end
        end else begin
          count_next = clk_count + 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_count == BIT_LAST) begin
          count_next  = '0;
          parity_next = rx_s;
          state_next  = STOP;
        end else begin
          count_next = clk_count + 16'd1;
        end
      end
`endif
      STOP: begin
        if (clk_count == BIT_LAST) begin
          count_next = '0;
`ifdef UART_RX_PARITY_EN
          perr_next = ^shift ^ parity_bit;
`endif
          if (rx_s) begin
            data_next  = shift;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = WAIT_HIGH;
          end
        end else begin
          count_next = clk_count + 16'd1;
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line recovers so a break is not read as a start bit.
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rx_busy   = (state != IDLE);
  assign fsm_state = state;

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; pairs with the existing UART transmitter: same clk_freq/baud_rate parameters, LSB-first framing, idle-high line.
- Synchronises the asynchronous serial input and validates the start bit at mid-bit.
- Samples 8 data bits and the stop bit at mid-bit, then presents the byte with a one-cycle valid pulse.
- Sits between the board RX pin and any byte consumer (loopback, command parser, FIFO).

Parameters:
- clk_freq, 50000000, system clock frequency in Hz.
- baud_rate, 9600, serial bit rate. clks_per_bit = clk_freq/baud_rate (integer division), required range 4..65535. half_bit = clks_per_bit/2.

Ports:
- clk, input, 1, system clock; all state on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- rx_line, input, 1, asynchronous serial input, idle high.
- rx_data, output, 8, last correctly framed byte; holds until the next good frame.
- rx_valid, output, 1, one-cycle pulse when rx_data updates.
- rx_busy, output, 1, high in every state except IDLE.
- frame_err, output, 1, one-cycle pulse when the stop bit is sampled low.
- parity_err, output, 1, one-cycle pulse on parity mismatch; constant 0 without UART_RX_PARITY_EN.

Behaviour:
- Reset (reset_n low, asynchronous):
  - rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, parity_err=0.
  - Synchroniser flops=1, state=IDLE, counters=0.
  - Reset mid-frame aborts the frame with no pulse.
- Synchroniser: two flops; rx_s is rx_line delayed 2 cycles. All decisions use rx_s only.
- Counters: clk_count is 16 bits; bit_index is 3 bits.
- IDLE:
  - rx_s==0 -> START, clk_count=0.
  - Otherwise stay.
- START:
  - Count to half_bit-1, then sample rx_s.
  - rx_s==0 -> DATA, clk_count=0, bit_index=0.
  - rx_s==1 -> glitch; return to IDLE with no pulse.
- DATA:
  - At clk_count==clks_per_bit-1, sample rx_s into shift[bit_index] (LSB first) and reset clk_count.
  - After bit 7 -> STOP (or PARITY when the feature is on).
- STOP: at clks_per_bit-1, sample rx_s.
  - rx_s==1: rx_data<=shift and rx_valid=1 for one cycle, both on the same edge; -> IDLE.
  - rx_s==0: frame_err=1 for one cycle; rx_data unchanged; -> WAIT_HIGH.
- WAIT_HIGH (break / line stuck low): stay until rx_s==1, then -> IDLE. Prevents re-triggering on a held-low line.
- Latency: rx_valid rises about 9.5 bit periods + 3 clk after the falling edge of the start bit on rx_line.
- Back-to-back frames: the next start edge is accepted in IDLE right after STOP. The half-bit early exit provides slack for up to about 5% baud mismatch.
- rx_valid and frame_err are never asserted in the same cycle.
- No backpressure: the consumer must take rx_data in the rx_valid cycle or before the next frame completes.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; state PARITY sits between DATA and STOP and samples at mid-bit.
  - On mismatch (^shift ^ parity_bit != 0), parity_err pulses in the STOP-sample cycle, concurrent with rx_valid or frame_err.
  - rx_data is still updated if the stop bit is good.
- Undefined: 8N1 only; parity_err tied 0; PARITY state absent.

Decomposition:
- Shared package uart_pkg:
  - State encodings IDLE, START, DATA, PARITY, STOP, WAIT_HIGH (3-bit).
  - Helper function for clks_per_bit; DATA_BITS=8.
  - Reused by the transmitter in future updates.
- Sub-module sync_2ff: generic 2-flop synchroniser with a reset value parameter (here 1).
- Everything else lives in the top module.

Test Plan (clk_freq=1000000, baud_rate=100000 -> 10 clks/bit, half=5):
- Drive frame 0x A5 (start, 1,0,1,0,0,1,0,1, stop=1) -> single rx_valid pulse, rx_data=0xA5, frame_err=0, rx_busy low after.
- 2-clk low glitch on an idle line -> returns to IDLE, no rx_valid, no frame_err, rx_data unchanged.
- Frame 0x3C with stop=0, then line held low for 30 clks -> frame_err single pulse, rx_data keeps its prior value, no new frame until the line is high.
- Back-to-back 0x00 then 0xFF with no idle gap -> two rx_valid pulses, values 0x00 then 0xFF.
- Assert reset_n low at bit 4 of a 0x55 frame, release, then send 0x81 -> no pulse for the aborted frame; rx_data=0x81 after the second frame.
- With UART_RX_PARITY_EN: 0x07 with parity bit 0 (wrong) -> rx_valid and parity_err together, rx_data=0x07; the same byte with parity 1 -> parity_err=0.
